mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
//  - Upstream control stage for the 2:1 mux datapath: arbitrates two valid/ready source streams (A, B).
//  - Drives the mux select and a registered, handshaked output.
//  - sel=0 selects A and sel=1 selects B, the same encoding as the downstream 2:1 mux.
//  - Single-entry output pipeline register with round-robin fairness.
// PARAMETERS
//  - W  1  data width of a_data, b_data and y_data (1 = one-bit mux case)
// PORTS
//  - clk      input   1  single clock; all state updates on posedge
//  - rst      input   1  reset, synchronous, active-high
//  - a_valid  input   1  source A has data
//  - a_data   input   W  source A payload
//  - a_ready  output  1  A transfer occurs this cycle when a_valid && a_ready
//  - b_valid  input   1  source B has data
//  - b_data   input   W  source B payload
//  - b_ready  output  1  B transfer occurs this cycle when b_valid && b_ready
//  - y_valid  output  1  output register holds data
//  - y_data   output  W  registered payload
//  - y_ready  input   1  downstream accepts; transfer when y_valid && y_ready
//  - sel      output  1  source of the data currently in the output register (0=A, 1=B)
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-high.
//  - Reset values:
//    - y_valid=0, y_data='0, sel=0
//    - last_grant=SRC_B, so A wins the first contention
//    - a_ready=0, b_ready=0 while rst=1
//  - State machine (st):
//    - EMPTY -> FULL on load
//    - FULL -> EMPTY on drain without load
//    - FULL -> FULL on drain+load (same-cycle refill) or on stall
//  - load_ok = (st==EMPTY) || (y_valid && y_ready)
//  - Grant (combinational, evaluated only when load_ok):
//    - only A valid -> A; only B valid -> B
//    - both valid -> the side != last_grant; neither valid -> no grant
//  - a_ready = load_ok && grant==A; b_ready = load_ok && grant==B.
//    - At most one ready is high per cycle.
//    - ready never depends on the same source's valid beyond the grant logic.
//  - On load: y_data <= granted data, sel <= granted source, last_grant <= granted source, y_valid <= 1.
//  - Latency: 1 cycle from accepted input to y_valid. Full throughput of 1 transfer/cycle when y_ready=1.
//  - Stall (y_valid && !y_ready): y_data and sel are held stable; both readies are 0.
//  - Drain with no request: y_valid <= 0 next cycle; y_data and sel keep their last values.
//  - Reset mid-operation: buffered data is discarded; outputs return to reset values on the next edge.
//  - Fairness under continuous contention: grants alternate A,B,A,B...; no source waits more than 1 grant.
// CONFIGURATION
//  - Macro MUX_SEL_ARBITER_FIXED_PRIO_EN:
//    - defined: fixed priority, A always wins contention; last_grant is not used for the decision.
//    - undefined (default): round-robin as described above.
//  - Port list is identical in both builds.
// STRUCTURE
//  - Package mux_arb_pkg:
//    - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_t
//    - typedef enum logic {EMPTY, FULL} arb_st_t
//  - Sub-module rr_arb2: pure grant logic.
//    - Inputs: req[1:0], last_grant, en.
//    - Outputs: gnt_valid, gnt (src_t).
//    - The macro is handled inside rr_arb2 only.
//  - Top: output register, FSM and ready generation.
// TESTING
//  - Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1.
//    - Expect y_valid=0, a_ready=b_ready=0, sel=0.
//  - Single source: W=1, a_valid=1, a_data=1, b_valid=0, y_ready=1.
//    - Expect a_ready=1; next cycle y_valid=1, y_data=1, sel=0.
//  - Contention: a_valid=b_valid=1, a_data=0, b_data=1, y_ready=1 for 4 cycles.
//    - Expect sel sequence 0,1,0,1 and y_data 0,1,0,1.
//    - With FIXED_PRIO_EN: sel 0,0,0,0.
//  - Backpressure: load B (b_data=1), then y_ready=0 for 3 cycles with a_valid=1.
//    - Expect y_data=1 and sel=1 held, a_ready=0.
//    - When y_ready=1: same-cycle refill from A, so sel=0 next cycle.
//  - Reset mid-stream: assert rst while y_valid=1 and y_ready=0.
//    - Expect y_valid=0 next cycle.
//    - First post-reset contention grants A.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the mux_sel_arbiter control stage: source encoding
// (matches the downstream 2:1 mux select) and output-register occupancy.
package mux_arb_pkg;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_st_t;

   function automatic src_t other_src(input src_t s);
      return (s == SRC_A) ? SRC_B : SRC_A;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_arb2.sv
// Two-requester grant logic (module rr_arb2), purely combinational.
// MUX_SEL_ARBITER_FIXED_PRIO_EN: when defined, A always wins contention.
module rr_arb2
   import mux_arb_pkg::*;
(
   input  logic [1:0] req,
   input  src_t       last_grant,
   input  logic       en,
   output logic       gnt_valid,
   output src_t       gnt
);

`ifndef MUX_SEL_ARBITER_FIXED_PRIO_EN
   src_t contend_winner;
   assign contend_winner = other_src(last_grant);
`endif

   always_comb begin
      gnt_valid = 1'b0;
      gnt       = SRC_A;
      if (en) begin
         case (req)
            2'b01: begin
               gnt_valid = 1'b1;
               gnt       = SRC_A;
            end
            2'b10: begin
               gnt_valid = 1'b1;
               gnt       = SRC_B;
            end
            2'b11: begin
               gnt_valid = 1'b1;
`ifdef MUX_SEL_ARBITER_FIXED_PRIO_EN
               gnt       = SRC_A;
`else
               gnt       = contend_winner;
`endif
            end
            default: begin
               gnt_valid = 1'b0;
               gnt       = SRC_A;
            end
         endcase
      end
   end

`ifdef MUX_SEL_ARBITER_FIXED_PRIO_EN
   // last_grant only matters for round-robin; keep it visibly consumed.
   logic unused_last;
   assign unused_last = last_grant;
`endif

endmodule

// File: rtl/mux_sel_arbiter.sv
// Arbitrates sources A/B into a single-entry handshaked output register and
// drives the mux select. Build option: MUX_SEL_ARBITER_FIXED_PRIO_EN (in rr_arb2).
//
// state | meaning
// EMPTY | output register holds nothing; any granted source may load
// FULL  | output register valid; reload only in a cycle where y_ready drains it
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_valid,
   input  logic [W-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [W-1:0] b_data,
   output logic         b_ready,
   output logic         y_valid,
   output logic [W-1:0] y_data,
   input  logic         y_ready,
   output logic         sel
);

   arb_st_t      st_q, st_d;
   logic [W-1:0] y_data_q, y_data_d;
   src_t         sel_q, sel_d;
   src_t         last_grant_q, last_grant_d;

   logic load_ok;
   logic gnt_valid;
   src_t gnt;

   // FULL implies y_valid, so draining reduces to y_ready in that state.
   assign load_ok = !rst && ((st_q == EMPTY) || y_ready);

   rr_arb2 u_arb (
      .req       ({b_valid, a_valid}),
      .last_grant(last_grant_q),
      .en        (load_ok),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   assign a_ready = gnt_valid && (gnt == SRC_A);
   assign b_ready = gnt_valid && (gnt == SRC_B);

   always_comb begin
      st_d         = st_q;
      y_data_d     = y_data_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;

      case (st_q)
         EMPTY: begin
            if (gnt_valid) st_d = FULL;
         end
         FULL: begin
            if (y_ready) st_d = gnt_valid ? FULL : EMPTY;
         end
         default: st_d = EMPTY;
      endcase

      if (gnt_valid) begin
         y_data_d     = (gnt == SRC_B) ? b_data : a_data;
         sel_d        = gnt;
         last_grant_d = gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q         <= EMPTY;
         y_data_q     <= '0;
         sel_q        <= SRC_A;
         last_grant_q <= SRC_B;
      end else begin
         st_q         <= st_d;
         y_data_q     <= y_data_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign y_valid = (st_q == FULL);
   assign y_data  = y_data_q;
   assign sel     = sel_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboarded random + directed bench for mux_sel_arbiter.
module tb_mux_sel_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
   logic [W-1:0] a_data = '0, b_data = '0;
   logic         a_ready, b_ready, y_valid, sel;
   logic [W-1:0] y_data;

   mux_sel_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
      .sel(sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         src;
   } item_t;

   item_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // reference model: occupancy, last winner, whether state is known yet
   bit m_full  = 0;
   bit m_last  = 1;
   bit m_known = 0;
   bit m_after_rst = 0;
   int wait_b = 0, wait_a = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit av, input int ad, input bit bv,
                        input int bd, input bit yr);
      bit lok, ga, gb;
      @(posedge clk);
      #1;
      rst = r; a_valid = av; a_data = W'(ad); b_valid = bv; b_data = W'(bd); y_ready = yr;
      #2;
      ga = 0; gb = 0;
      if (!r) begin
         lok = !m_full || yr;
         if (lok) begin
            if (av && bv) begin
`ifdef MUX_SEL_ARBITER_FIXED_PRIO_EN
               ga = 1;
`else
               if (m_last) ga = 1; else gb = 1;
`endif
            end else if (av) ga = 1;
            else if (bv) gb = 1;
         end
      end
      check("a_ready", a_ready, ga);
      check("b_ready", b_ready, gb);
      if (m_known) check("y_valid", y_valid, m_full);
      if (m_after_rst) begin
         check("sel_after_rst", sel, 0);
         check("y_data_after_rst", y_data, 0);
      end
`ifndef MUX_SEL_ARBITER_FIXED_PRIO_EN
      if (!r && (ga || gb)) begin
         if (av && bv) begin
            check("fairness", (ga ? wait_a : wait_b) <= 1, 1);
         end
         if (ga) begin wait_a = 0; if (bv) wait_b++; end
         else    begin wait_b = 0; if (av) wait_a++; end
      end
`endif
      if (r) begin
         m_full = 0; m_last = 1; m_known = 1; m_after_rst = 1;
         wait_a = 0; wait_b = 0;
         exp_q.delete();
      end else begin
         m_after_rst = 0;
         if (ga || gb) begin
            item_t it;
            it.data = ga ? W'(ad) : W'(bd);
            it.src  = gb;
            exp_q.push_back(it);
            m_full = 1;
            m_last = gb;
         end else if (m_full && yr) begin
            m_full = 0;
         end
         if (!av && !bv) begin wait_a = 0; wait_b = 0; end
      end
   endtask

   // Monitor: output register content must match the oldest expectation;
   // popped on each downstream handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && y_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               check("y_data", y_data, exp_q[0].data);
               check("sel", sel, exp_q[0].src);
               if (y_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      // reset held 2 cycles with both sources requesting
      cycle(1, 1, 1, 1, 1, 1);
      cycle(1, 1, 1, 1, 1, 1);
      // single source
      cycle(0, 1, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // contention, 4 cycles
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // backpressure: load B, stall with A pending, then release
      cycle(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 5, 0, 0, 0);
      cycle(0, 1, 5, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // reset mid-stream while stalled
      cycle(0, 1, 3, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 1, 2, 1, 7, 0);
      cycle(0, 1, 6, 1, 9, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0));
      end
      // drain
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
